// File: rtl/neuron_mac.sv
// Weighted-sum stage of one neuron: signed MAC of a frame of inputs against a loadable
// weight RAM, plus bias, with a saturated result and a single-cycle valid pulse.
module neuron_mac #(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int numInputs      = 30,
    parameter int addrWidth      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [dataWidth-1:0]   myinput,
    input  logic                   myinputValid,
    input  logic                   weightValid,
    input  logic [addrWidth-1:0]   weightAddr,
    input  logic [dataWidth-1:0]   weightValue,
    input  logic                   biasValid,
    input  logic [2*dataWidth-1:0] biasValue,
    output logic [2*dataWidth-1:0] out,
    output logic                   outvalid
);

    localparam int AccW = 2 * dataWidth;
    localparam logic [addrWidth-1:0] LastIdx = addrWidth'(numInputs - 1);
    localparam logic signed [AccW-1:0] SatMax = {1'b0, {(AccW-1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {1'b1, {(AccW-1){1'b0}}};

    // weightIntWidth only describes the weight format for the activation stage downstream.
    if (weightIntWidth >= dataWidth || (2 ** addrWidth) < numInputs) begin : g_param_check
        $error("neuron_mac: inconsistent parameters");
    end

    function automatic logic signed [AccW-1:0] sat_add(input logic signed [AccW-1:0] a,
                                                       input logic signed [AccW-1:0] b);
        logic signed [AccW-1:0] s;
        s = a + b;
        if (!a[AccW-1] && !b[AccW-1] && s[AccW-1]) return SatMax;
        if (a[AccW-1] && b[AccW-1] && !s[AccW-1]) return SatMin;
        return s;
    endfunction

    logic signed [dataWidth-1:0] wram [2**addrWidth];
    logic signed [dataWidth-1:0] x_q, w_q;

    logic [addrWidth-1:0]   cnt_q, cnt_d;
    logic                   v0_q, v0_d, last0_q, last0_d;
    logic                   v1_q, v1_d, last1_q, last1_d;
    logic                   fin_q, fin_d, pend_q, pend_d;
    logic signed [AccW-1:0] prod_q, prod_d, sum_q, sum_d, res_q, res_d;
    logic signed [AccW-1:0] bias_q, bias_d, out_q, out_d;
    logic                   outvalid_q, outvalid_d;
    logic                   is_last;

    // Weight RAM and operand registers carry no reset; RAM contents survive rst.
    always_ff @(posedge clk) begin
        if (weightValid) wram[weightAddr] <= $signed(weightValue);
        if (myinputValid) begin
            x_q <= $signed(myinput);
            w_q <= wram[cnt_q];
        end
    end

    assign is_last = (cnt_q == LastIdx);

    always_comb begin
        cnt_d      = cnt_q;
        v0_d       = myinputValid;
        last0_d    = myinputValid && is_last;
        v1_d       = v0_q;
        last1_d    = last0_q;
        prod_d     = prod_q;
        fin_d      = v1_q && last1_q;
        sum_d      = sum_q;
        res_d      = res_q;
        pend_d     = fin_q;
        bias_d     = biasValid ? $signed(biasValue) : bias_q;
        out_d      = pend_q ? res_q : out_q;
        outvalid_d = pend_q;

        if (myinputValid) cnt_d = is_last ? '0 : cnt_q + 1'b1;
        if (v0_q) prod_d = x_q * w_q;

        // Bias edge: finish this frame and seed the next one with any product already in flight.
        if (fin_q) begin
            res_d = sat_add(sum_q, bias_q);
            sum_d = v1_q ? prod_q : '0;
        end else if (v1_q) begin
            sum_d = sat_add(sum_q, prod_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            v0_q       <= 1'b0;
            last0_q    <= 1'b0;
            v1_q       <= 1'b0;
            last1_q    <= 1'b0;
            prod_q     <= '0;
            fin_q      <= 1'b0;
            sum_q      <= '0;
            res_q      <= '0;
            pend_q     <= 1'b0;
            bias_q     <= '0;
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            v0_q       <= v0_d;
            last0_q    <= last0_d;
            v1_q       <= v1_d;
            last1_q    <= last1_d;
            prod_q     <= prod_d;
            fin_q      <= fin_d;
            sum_q      <= sum_d;
            res_q      <= res_d;
            pend_q     <= pend_d;
            bias_q     <= bias_d;
            out_q      <= out_d;
            outvalid_q <= outvalid_d;
        end
    end

    assign out      = out_q;
    assign outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed frames plus randomized frames checked against a
// frame-level arithmetic model of the weighted sum.
module tb_neuron_mac;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] myinput = '0;
    logic          myinputValid = 1'b0;
    logic          weightValid = 1'b0;
    logic [AW-1:0] weightAddr = '0;
    logic [DW-1:0] weightValue = '0;
    logic          biasValid = 1'b0;
    logic [31:0]   biasValue = '0;
    logic [31:0]   out;
    logic          outvalid;

    neuron_mac #(
        .dataWidth(DW),
        .weightIntWidth(4),
        .numInputs(N),
        .addrWidth(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .myinput(myinput),
        .myinputValid(myinputValid),
        .weightValid(weightValid),
        .weightAddr(weightAddr),
        .weightValue(weightValue),
        .biasValid(biasValid),
        .biasValue(biasValue),
        .out(out),
        .outvalid(outvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_n  = 0;
    int          n_pulse = 0;
    exp_t        exp_q[$];
    logic [15:0] m_w[N];
    longint      m_acc = 0;
    int          m_cnt = 0;
    logic [31:0] m_bias = '0;
    logic [31:0] m_out = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    // Real-valued sum clamped to the 32-bit signed range.
    function automatic longint clamp_add(input longint a, input longint b);
        longint r;
        r = a + b;
        if (r > SMax) return SMax;
        if (r < SMin) return SMin;
        return r;
    endfunction

    function automatic longint s16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint s32(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // One clock: update the model for what the DUT samples, then check outputs after the edge.
    task automatic tick();
        exp_t   e;
        longint r;
        if (myinputValid) begin
            m_acc = clamp_add(m_acc, s16(myinput) * s16(m_w[m_cnt]));
            if (m_cnt == N - 1) begin
                r     = clamp_add(m_acc, s32(m_bias));
                e.due = edge_n + 1 + 4;
                e.val = r[31:0];
                exp_q.push_back(e);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (weightValid) m_w[weightAddr] = weightValue;
        if (biasValid) m_bias = biasValue;
        @(posedge clk);
        edge_n++;
        #1;
        if (outvalid === 1'b1) n_pulse++;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            check_eq("outvalid_hi", {63'd0, outvalid}, 64'd1);
            m_out = exp_q[0].val;
            void'(exp_q.pop_front());
        end else begin
            check_eq("outvalid_lo", {63'd0, outvalid}, 64'd0);
        end
        check_eq("out_value", {32'd0, out}, {32'd0, m_out});
    endtask

    task automatic idle(input int n);
        myinputValid = 1'b0;
        weightValid  = 1'b0;
        biasValid    = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [15:0] x);
        myinput      = x;
        myinputValid = 1'b1;
        tick();
        myinputValid = 1'b0;
        weightValid  = 1'b0;
    endtask

    task automatic load_weights(input logic [15:0] w);
        for (int i = 0; i < N; i++) begin
            weightValid = 1'b1;
            weightAddr  = AW'(i);
            weightValue = w;
            tick();
        end
        weightValid = 1'b0;
    endtask

    task automatic load_bias(input logic [31:0] b);
        biasValid = 1'b1;
        biasValue = b;
        tick();
        biasValid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_acc  = 0;
        m_cnt  = 0;
        m_bias = '0;
        m_out  = '0;
        #1;
        check_eq("rst_outvalid", {63'd0, outvalid}, 64'd0);
        check_eq("rst_out", {32'd0, out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("init_outvalid", {63'd0, outvalid}, 64'd0);
        check_eq("init_out", {32'd0, out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: unit weights, no bias
        load_weights(16'h1000);
        load_bias(32'h0);
        frame(16'h1000, 16'h2000, 16'h0800, 16'h0000);
        idle(6);
        check_eq("t1_out", {32'd0, out}, 64'h03800000);

        // 2: bias added once per frame
        load_bias(32'h01000000);
        frame(16'h1000, 16'h2000, 16'h0800, 16'h0000);
        idle(6);
        check_eq("t2_out", {32'd0, out}, 64'h04800000);

        // 3: negative weights
        load_bias(32'h0);
        load_weights(16'hF000);
        frame(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        idle(6);
        check_eq("t3_out", {32'd0, out}, 64'hFC000000);

        // 4: positive and negative saturation
        load_weights(16'h7FFF);
        frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        idle(6);
        check_eq("t4_pos_sat", {32'd0, out}, 64'h7FFFFFFF);
        frame(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        idle(6);
        check_eq("t4_neg_sat", {32'd0, out}, 64'h80000000);

        // 5: gapped frame A then back-to-back frame B
        load_weights(16'h1000);
        idle(2);
        n_pulse = 0;
        send(16'h1000);
        idle(1);
        send(16'h2000);
        idle(2);
        send(16'h0800);
        send(16'h0000);
        frame(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        idle(6);
        check_eq("t5_pulses", 64'(n_pulse), 64'd2);
        check_eq("t5_out_b", {32'd0, out}, 64'hFC000000);

        // 6: reset mid-frame discards partial sum, weights retained
        send(16'h1000);
        send(16'h2000);
        do_reset();
        n_pulse = 0;
        idle(6);
        check_eq("t6_no_pulse", 64'(n_pulse), 64'd0);
        check_eq("t6_out_zero", {32'd0, out}, 64'd0);
        frame(16'h1000, 16'h2000, 16'h0800, 16'h0000);
        idle(6);
        check_eq("t6_retained", {32'd0, out}, 64'h03800000);

        // Randomized frames: gaps, mid-frame weight writes, occasional bias changes
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle(5);
                load_bias($urandom);
            end
            for (int i = 0; i < N; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    weightValid = ($urandom_range(0, 3) == 0);
                    weightAddr  = AW'($urandom_range(0, N - 1));
                    weightValue = 16'($urandom);
                    tick();
                    weightValid = 1'b0;
                end
                weightValid = ($urandom_range(0, 4) == 0);
                weightAddr  = AW'($urandom_range(0, N - 1));
                weightValue = 16'($urandom);
                send(16'($urandom));
            end
        end
        idle(8);
        check_eq("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
